axi4_ram_master: RTL and testbench

- Single-outstanding AXI4 initiator that converts simple RAM-style requests (wr strobe / rd / addr / data) into single-beat AXI4 INCR transactions.
- It is the initiator-side counterpart of the AXI4 RAM bridge: one instance's AXI4 master port connects directly to a TCM top's AXI4 target port.
- Intended use is a debug/loader engine or a second SoC master.
- Exactly one transaction is in flight at a time; each accepted request ends with a one-cycle ack.

---
 rtl/axi4_ram_master.sv | 156 +++++++++++++++
 tb/tb_axi4_ram_master.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_ram_master.sv
// Single-outstanding AXI4 initiator: turns RAM-style wr/rd requests into
// single-beat INCR transactions and returns a one-cycle ack per request.
module axi4_ram_master #(
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic [3:0]  ram_wr_i,
  input  logic        ram_rd_i,
  input  logic [31:0] ram_addr_i,
  input  logic [31:0] ram_write_data_i,
  output logic        ram_accept_o,
  output logic        ram_ack_o,
  output logic [31:0] ram_read_data_o,
  output logic        ram_error_o,

  output logic        axi_awvalid_o,
  output logic [31:0] axi_awaddr_o,
  output logic [3:0]  axi_awid_o,
  output logic [7:0]  axi_awlen_o,
  output logic [1:0]  axi_awburst_o,
  input  logic        axi_awready_i,

  output logic        axi_wvalid_o,
  output logic [31:0] axi_wdata_o,
  output logic [3:0]  axi_wstrb_o,
  output logic        axi_wlast_o,
  input  logic        axi_wready_i,

  input  logic        axi_bvalid_i,
  input  logic [1:0]  axi_bresp_i,
  input  logic [3:0]  axi_bid_i,
  output logic        axi_bready_o,

  output logic        axi_arvalid_o,
  output logic [31:0] axi_araddr_o,
  output logic [3:0]  axi_arid_o,
  output logic [7:0]  axi_arlen_o,
  output logic [1:0]  axi_arburst_o,
  input  logic        axi_arready_i,

  input  logic        axi_rvalid_i,
  input  logic [31:0] axi_rdata_i,
  input  logic [1:0]  axi_rresp_i,
  input  logic [3:0]  axi_rid_i,
  input  logic        axi_rlast_i,
  output logic        axi_rready_o
);

  // state  | meaning
  // IDLE   | ready to accept a request
  // WR     | AW and/or W beat still outstanding
  // WRESP  | waiting for the B response
  // RADDR  | AR beat outstanding
  // RDATA  | waiting for the R beat
  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WRESP, S_RADDR, S_RDATA
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, data_q, rdata_q;
  logic [3:0]  strb_q;
  logic        aw_pend_q, w_pend_q, ack_q, err_q;

  logic wr_req, rd_req, aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic unused_bits;

  assign unused_bits = ^{ram_addr_i[1:0], axi_bresp_i[0], axi_rresp_i[0]};

  // Write wins when both request kinds arrive together; the read is dropped.
  assign wr_req = (state_q == S_IDLE) & (|ram_wr_i);
  assign rd_req = (state_q == S_IDLE) & ram_rd_i & ~(|ram_wr_i);
  assign aw_hs  = axi_awvalid_o & axi_awready_i;
  assign w_hs   = axi_wvalid_o & axi_wready_i;
  assign ar_hs  = axi_arvalid_o & axi_arready_i;
  assign b_hs   = axi_bready_o & axi_bvalid_i;
  assign r_hs   = axi_rready_o & axi_rvalid_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (wr_req)      state_d = S_WR;
        else if (rd_req) state_d = S_RADDR;
      end
      S_WR:    if ((~aw_pend_q | aw_hs) & (~w_pend_q | w_hs)) state_d = S_WRESP;
      S_WRESP: if (b_hs) state_d = S_IDLE;
      S_RADDR: if (ar_hs) state_d = S_RDATA;
      S_RDATA: if (r_hs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Valids derive from state so an async reset drops them immediately.
  always_comb begin
    ram_accept_o  = (state_q == S_IDLE);
    axi_awvalid_o = (state_q == S_WR) & aw_pend_q;
    axi_wvalid_o  = (state_q == S_WR) & w_pend_q;
    axi_bready_o  = (state_q == S_WRESP);
    axi_arvalid_o = (state_q == S_RADDR);
    axi_rready_o  = (state_q == S_RDATA);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      rdata_q   <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (wr_req) begin
        addr_q    <= {ram_addr_i[31:2], 2'b00};
        data_q    <= ram_write_data_i;
        strb_q    <= ram_wr_i;
        aw_pend_q <= 1'b1;
        w_pend_q  <= 1'b1;
      end else if (rd_req) begin
        addr_q    <= {ram_addr_i[31:2], 2'b00};
      end
      if (aw_hs) aw_pend_q <= 1'b0;
      if (w_hs)  w_pend_q  <= 1'b0;
      if (r_hs)  rdata_q   <= axi_rdata_i;
      ack_q <= b_hs | r_hs;
      if (b_hs)      err_q <= axi_bresp_i[1] | (axi_bid_i != AXI_ID);
      else if (r_hs) err_q <= axi_rresp_i[1] | (axi_rid_i != AXI_ID) | ~axi_rlast_i;
      else           err_q <= 1'b0;
    end
  end

  assign ram_ack_o       = ack_q;
  assign ram_error_o     = err_q;
  assign ram_read_data_o = rdata_q;

  assign axi_awaddr_o  = addr_q;
  assign axi_awid_o    = AXI_ID;
  assign axi_awlen_o   = 8'd0;
  assign axi_awburst_o = 2'b01;
  assign axi_wdata_o   = data_q;
  assign axi_wstrb_o   = strb_q;
  assign axi_wlast_o   = 1'b1;
  assign axi_araddr_o  = addr_q;
  assign axi_arid_o    = AXI_ID;
  assign axi_arlen_o   = 8'd0;
  assign axi_arburst_o = 2'b01;

endmodule

// File: tb/tb_axi4_ram_master.sv
// Directed bench for axi4_ram_master: behavioural AXI4 slave with programmable
// wait states, plus an ack scoreboard fed as requests are issued.
module tb_axi4_ram_master;

  localparam logic [3:0] AXI_ID = 4'd0;

  logic        clk_i, rst_i;
  logic [3:0]  ram_wr_i;
  logic        ram_rd_i;
  logic [31:0] ram_addr_i, ram_write_data_i;
  logic        ram_accept_o, ram_ack_o, ram_error_o;
  logic [31:0] ram_read_data_o;
  logic        axi_awvalid_o, axi_awready_i;
  logic [31:0] axi_awaddr_o;
  logic [3:0]  axi_awid_o;
  logic [7:0]  axi_awlen_o;
  logic [1:0]  axi_awburst_o;
  logic        axi_wvalid_o, axi_wlast_o, axi_wready_i;
  logic [31:0] axi_wdata_o;
  logic [3:0]  axi_wstrb_o;
  logic        axi_bvalid_i, axi_bready_o;
  logic [1:0]  axi_bresp_i;
  logic [3:0]  axi_bid_i;
  logic        axi_arvalid_o, axi_arready_i;
  logic [31:0] axi_araddr_o;
  logic [3:0]  axi_arid_o;
  logic [7:0]  axi_arlen_o;
  logic [1:0]  axi_arburst_o;
  logic        axi_rvalid_i, axi_rlast_i, axi_rready_o;
  logic [31:0] axi_rdata_i;
  logic [1:0]  axi_rresp_i;
  logic [3:0]  axi_rid_i;

  axi4_ram_master #(.AXI_ID(AXI_ID)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ram_wr_i(ram_wr_i), .ram_rd_i(ram_rd_i), .ram_addr_i(ram_addr_i),
    .ram_write_data_i(ram_write_data_i), .ram_accept_o(ram_accept_o),
    .ram_ack_o(ram_ack_o), .ram_read_data_o(ram_read_data_o), .ram_error_o(ram_error_o),
    .axi_awvalid_o(axi_awvalid_o), .axi_awaddr_o(axi_awaddr_o), .axi_awid_o(axi_awid_o),
    .axi_awlen_o(axi_awlen_o), .axi_awburst_o(axi_awburst_o), .axi_awready_i(axi_awready_i),
    .axi_wvalid_o(axi_wvalid_o), .axi_wdata_o(axi_wdata_o), .axi_wstrb_o(axi_wstrb_o),
    .axi_wlast_o(axi_wlast_o), .axi_wready_i(axi_wready_i),
    .axi_bvalid_i(axi_bvalid_i), .axi_bresp_i(axi_bresp_i), .axi_bid_i(axi_bid_i),
    .axi_bready_o(axi_bready_o),
    .axi_arvalid_o(axi_arvalid_o), .axi_araddr_o(axi_araddr_o), .axi_arid_o(axi_arid_o),
    .axi_arlen_o(axi_arlen_o), .axi_arburst_o(axi_arburst_o), .axi_arready_i(axi_arready_i),
    .axi_rvalid_i(axi_rvalid_i), .axi_rdata_i(axi_rdata_i), .axi_rresp_i(axi_rresp_i),
    .axi_rid_i(axi_rid_i), .axi_rlast_i(axi_rlast_i), .axi_rready_o(axi_rready_o)
  );

  typedef struct {
    logic        is_read;
    logic        err;
    logic [31:0] data;
  } txn_t;

  txn_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  logic [31:0] model_rdata = '0;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic expect_txn(input logic is_read, input logic err, input logic [31:0] data);
    txn_t t;
    t.is_read = is_read;
    t.err     = err;
    t.data    = data;
    sb.push_back(t);
  endtask

  task automatic issue(input logic [3:0] wr, input logic rd, input logic [31:0] addr,
                       input logic [31:0] data);
    check("accept_idle", ram_accept_o, 1);
    ram_wr_i = wr; ram_rd_i = rd; ram_addr_i = addr; ram_write_data_i = data;
    tick();
    ram_wr_i = '0; ram_rd_i = 1'b0;
  endtask

  task automatic wait_ack(input int budget);
    int n = 0;
    while (!ram_ack_o && n < budget) begin
      tick();
      n++;
    end
    check("ack_within_budget", ram_ack_o, 1);
  endtask

  // Slave: each ready/valid rises once the partner has waited <delay> cycles.
  initial begin
    int cnt = 0;
    axi_awready_i = 1'b0;
    forever begin
      tick();
      if (!rst_i)              begin axi_awready_i = 1'b0; cnt = 0; end
      else if (axi_awvalid_o)  begin axi_awready_i = (cnt >= aw_delay); cnt++; end
      else                     begin axi_awready_i = 1'b0; cnt = 0; end
    end
  end

  initial begin
    int cnt = 0;
    axi_wready_i = 1'b0;
    forever begin
      tick();
      if (!rst_i)             begin axi_wready_i = 1'b0; cnt = 0; end
      else if (axi_wvalid_o)  begin axi_wready_i = (cnt >= w_delay); cnt++; end
      else                    begin axi_wready_i = 1'b0; cnt = 0; end
    end
  end

  initial begin
    int cnt = 0;
    axi_arready_i = 1'b0;
    forever begin
      tick();
      if (!rst_i)              begin axi_arready_i = 1'b0; cnt = 0; end
      else if (axi_arvalid_o)  begin axi_arready_i = (cnt >= ar_delay); cnt++; end
      else                     begin axi_arready_i = 1'b0; cnt = 0; end
    end
  end

  initial begin
    int cnt = 0;
    axi_bvalid_i = 1'b0;
    forever begin
      tick();
      if (!rst_i)             begin axi_bvalid_i = 1'b0; cnt = 0; end
      else if (axi_bready_o)  begin axi_bvalid_i = (cnt >= b_delay); cnt++; end
      else                    begin axi_bvalid_i = 1'b0; cnt = 0; end
    end
  end

  initial begin
    int cnt = 0;
    axi_rvalid_i = 1'b0;
    forever begin
      tick();
      if (!rst_i)             begin axi_rvalid_i = 1'b0; cnt = 0; end
      else if (axi_rready_o)  begin axi_rvalid_i = (cnt >= r_delay); cnt++; end
      else                    begin axi_rvalid_i = 1'b0; cnt = 0; end
    end
  end

  // Scoreboard: every ack must match the oldest issued request.
  initial begin
    txn_t t;
    forever begin
      tick();
      if (ram_ack_o) begin
        check("ack_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          t = sb.pop_front();
          if (t.is_read) model_rdata = t.data;
          check("ack_error", ram_error_o, t.err);
          check("ack_read_data", ram_read_data_o, model_rdata);
        end
      end
    end
  end

  initial begin
    rst_i = 1'b0;
    ram_wr_i = '0; ram_rd_i = 1'b0; ram_addr_i = '0; ram_write_data_i = '0;
    axi_bresp_i = 2'b00; axi_bid_i = AXI_ID;
    axi_rdata_i = '0; axi_rresp_i = 2'b00; axi_rid_i = AXI_ID; axi_rlast_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_accept", ram_accept_o, 1);
    check("rst_awvalid", axi_awvalid_o, 0);
    check("rst_wvalid", axi_wvalid_o, 0);
    check("rst_arvalid", axi_arvalid_o, 0);
    check("rst_bready", axi_bready_o, 0);
    check("rst_rready", axi_rready_o, 0);
    check("rst_ack", ram_ack_o, 0);
    check("rst_error", ram_error_o, 0);
    check("rst_rdata", ram_read_data_o, 0);
    rst_i = 1'b1;
    tick();

    // zero-wait write: ack lands exactly three cycles after the request
    expect_txn(1'b0, 1'b0, '0);
    issue(4'hF, 1'b0, 32'h0000_1003, 32'hDEAD_BEEF);
    check("w1_awvalid", axi_awvalid_o, 1);
    check("w1_wvalid", axi_wvalid_o, 1);
    check("w1_awaddr", axi_awaddr_o, 32'h0000_1000);
    check("w1_wdata", axi_wdata_o, 32'hDEAD_BEEF);
    check("w1_wstrb", axi_wstrb_o, 4'hF);
    check("w1_wlast", axi_wlast_o, 1);
    check("w1_awlen", axi_awlen_o, 0);
    check("w1_awburst", axi_awburst_o, 2'b01);
    check("w1_awid", axi_awid_o, AXI_ID);
    check("w1_accept_busy", ram_accept_o, 0);
    tick();
    check("w1_bready", axi_bready_o, 1);
    check("w1_awvalid_drop", axi_awvalid_o, 0);
    check("w1_wvalid_drop", axi_wvalid_o, 0);
    check("w1_no_early_ack", ram_ack_o, 0);
    tick();
    check("w1_ack_cycle3", ram_ack_o, 1);
    tick();

    // read with five arready wait cycles
    ar_delay = 5;
    axi_rdata_i = 32'h1234_5678;
    expect_txn(1'b1, 1'b0, 32'h1234_5678);
    issue(4'h0, 1'b1, 32'h0000_2000, '0);
    check("r1_araddr", axi_araddr_o, 32'h0000_2000);
    check("r1_arlen", axi_arlen_o, 0);
    check("r1_arburst", axi_arburst_o, 2'b01);
    check("r1_arid", axi_arid_o, AXI_ID);
    for (int i = 0; i < 5; i++) begin
      check("r1_arvalid_held", axi_arvalid_o, 1);
      check("r1_rready_low", axi_rready_o, 0);
      tick();
    end
    wait_ack(10);
    tick();
    ar_delay = 0;

    // AW delayed four cycles, W immediate
    aw_delay = 4;
    expect_txn(1'b0, 1'b0, '0);
    issue(4'hF, 1'b0, 32'h0000_3000, 32'h55AA_55AA);
    check("w2_wvalid_c1", axi_wvalid_o, 1);
    tick();
    for (int c = 2; c <= 5; c++) begin
      check("w2_awvalid_held", axi_awvalid_o, 1);
      check("w2_wvalid_done", axi_wvalid_o, 0);
      check("w2_bready_wait", axi_bready_o, 0);
      tick();
    end
    check("w2_awvalid_drop", axi_awvalid_o, 0);
    check("w2_bready", axi_bready_o, 1);
    wait_ack(5);
    tick();
    aw_delay = 0;

    // error responses
    axi_bresp_i = 2'b10;
    expect_txn(1'b0, 1'b1, '0);
    issue(4'hF, 1'b0, 32'h0000_0040, 32'h1);
    wait_ack(10);
    tick();
    axi_bresp_i = 2'b00;

    axi_rid_i = 4'd5;
    axi_rdata_i = 32'hCAFE_F00D;
    expect_txn(1'b1, 1'b1, 32'hCAFE_F00D);
    issue(4'h0, 1'b1, 32'h0000_0044, '0);
    wait_ack(10);
    tick();
    axi_rid_i = AXI_ID;

    axi_rlast_i = 1'b0;
    axi_rdata_i = 32'h0BAD_C0DE;
    expect_txn(1'b1, 1'b1, 32'h0BAD_C0DE);
    issue(4'h0, 1'b1, 32'h0000_0048, '0);
    wait_ack(10);
    tick();
    axi_rlast_i = 1'b1;

    // simultaneous write and read: only the write goes out
    expect_txn(1'b0, 1'b0, '0);
    issue(4'h3, 1'b1, 32'h0000_0050, 32'h1122_3344);
    check("wr_rd_arvalid_c1", axi_arvalid_o, 0);
    check("wr_rd_wstrb", axi_wstrb_o, 4'h3);
    check("wr_rd_accept_wr", ram_accept_o, 0);
    tick();
    check("wr_rd_arvalid_c2", axi_arvalid_o, 0);
    check("wr_rd_accept_wresp", ram_accept_o, 0);
    tick();
    check("wr_rd_ack", ram_ack_o, 1);
    check("wr_rd_arvalid_c3", axi_arvalid_o, 0);

    // new read accepted in the same cycle as the previous ack
    axi_rdata_i = 32'h600D_F00D;
    expect_txn(1'b1, 1'b0, 32'h600D_F00D);
    issue(4'h0, 1'b1, 32'h0000_0060, '0);
    check("b2b_arvalid", axi_arvalid_o, 1);
    wait_ack(10);
    tick();

    // reset while arvalid is up: abort, no ack
    ar_delay = 10;
    issue(4'h0, 1'b1, 32'h0000_0070, '0);
    check("abort_arvalid_pre", axi_arvalid_o, 1);
    #2;
    rst_i = 1'b0;
    model_rdata = '0;
    #1;
    check("abort_arvalid_async", axi_arvalid_o, 0);
    check("abort_accept", ram_accept_o, 1);
    repeat (2) @(posedge clk_i);
    #1;
    check("abort_no_ack", ram_ack_o, 0);
    check("abort_rdata_cleared", ram_read_data_o, 0);
    rst_i = 1'b1;
    ar_delay = 0;
    axi_rdata_i = 32'h89AB_CDEF;
    tick();
    expect_txn(1'b1, 1'b0, 32'h89AB_CDEF);
    issue(4'h0, 1'b1, 32'h0000_0080, '0);
    wait_ack(10);
    tick();
    tick();
    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
